// File: rtl/tbt_iq_accumulator_pkg.sv
// Site constants and FSM encodings shared by the TbT integrator files.
package tbt_iq_accumulator_pkg;

   localparam int SITE_SAMPLES_PER_TURN = 81;

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/tbt_iq_accum.sv
// One signed turn accumulator: load restarts the sum, add extends it, dump zeroes it.
// sum_o is the running sum including the current sample, for capture at turn end.
module tbt_iq_accum #(
   parameter int IN_W  = 33,
   parameter int ACC_W = 40
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic                    add_i,
   input  logic                    dump_i,
   input  logic signed [IN_W-1:0]  sample_i,
   output logic signed [ACC_W-1:0] sum_o
);

   logic signed [ACC_W-1:0] acc_q, acc_d, ext;

   assign ext   = ACC_W'(sample_i);
   assign sum_o = (load_i ? '0 : acc_q) + ext;

   // Dump wins so a single-sample turn still leaves the accumulator empty.
   always_comb begin
      acc_d = acc_q;
      if (dump_i)               acc_d = '0;
      else if (load_i || add_i) acc_d = sum_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/tbt_iq_accumulator.sv
// Turn-by-turn I/Q integrator: sums SAMPLES_PER_TURN mixer products per turn,
// aligned to the EVR TbT marker with flywheel and saturating misalignment count.
module tbt_iq_accumulator
   import tbt_iq_accumulator_pkg::*;
#(
   parameter int PRODUCT_WIDTH    = 33,
   parameter int SAMPLES_PER_TURN = SITE_SAMPLES_PER_TURN,
   parameter int ACC_WIDTH        = PRODUCT_WIDTH + $clog2(SAMPLES_PER_TURN),
   parameter int ERR_COUNT_WIDTH  = 16
) (
   input  logic                              adcClk_i,
   input  logic                              adcReset_i,
   input  logic                              tbtMarker_i,
   input  logic                              inValid_i,
   input  logic signed [PRODUCT_WIDTH-1:0]   inI_i,
   input  logic signed [PRODUCT_WIDTH-1:0]   inQ_i,
   input  logic                              clearErrors_i,
   output logic                              tbtValid_o,
   output logic signed [ACC_WIDTH-1:0]       tbtI_o,
   output logic signed [ACC_WIDTH-1:0]       tbtQ_o,
   output logic                              tbtLocked_o,
   output logic [ERR_COUNT_WIDTH-1:0]        markerErrorCount_o
);

   localparam int               CNT_W   = $clog2(SAMPLES_PER_TURN + 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SAMPLES_PER_TURN);

   logic [0:0]                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       mkPend_q, mkPend_d;
   logic [ERR_COUNT_WIDTH-1:0] err_q, err_d;
   logic                       tbtValid_q, tbtValid_d;
   logic signed [ACC_WIDTH-1:0] tbtI_q, tbtI_d, tbtQ_q, tbtQ_d;
   logic signed [ACC_WIDTH-1:0] sumI, sumQ;
   logic                       mk, mkSamp, load, add, dump, errInc, turnEnd;

   assign mk     = mkPend_q | tbtMarker_i;
   assign mkSamp = inValid_i & mk;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mkPend_d   = mk & ~inValid_i;
      load       = 1'b0;
      add        = 1'b0;
      dump       = 1'b0;
      errInc     = 1'b0;
      turnEnd    = 1'b0;
      err_d      = err_q;
      tbtValid_d = 1'b0;
      tbtI_d     = tbtI_q;
      tbtQ_d     = tbtQ_q;

      if (inValid_i) begin
         case (state_q)
            ST_HUNT: begin
               if (mkSamp) begin
                  state_d = ST_LOCKED;
                  load    = 1'b1;
                  cnt_d   = CNT_W'(1);
               end
            end
            default: begin
               // A marker landing mid-turn restarts the turn on this sample.
               if (mkSamp && cnt_q != '0) begin
                  load   = 1'b1;
                  errInc = 1'b1;
                  cnt_d  = CNT_W'(1);
               end else begin
                  add    = 1'b1;
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end

      if ((load || add) && cnt_d == CNT_END) begin
         turnEnd    = 1'b1;
         dump       = 1'b1;
         cnt_d      = '0;
         tbtValid_d = 1'b1;
         tbtI_d     = sumI;
         tbtQ_d     = sumQ;
      end

      if (errInc) begin
         if (clearErrors_i) err_d = ERR_COUNT_WIDTH'(1);
         else if (~&err_q)  err_d = err_q + ERR_COUNT_WIDTH'(1);
      end else if (clearErrors_i) begin
         err_d = '0;
      end
   end

   always_ff @(posedge adcClk_i) begin
      if (adcReset_i) begin
         state_q    <= ST_HUNT;
         cnt_q      <= '0;
         mkPend_q   <= 1'b0;
         err_q      <= '0;
         tbtValid_q <= 1'b0;
         tbtI_q     <= '0;
         tbtQ_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mkPend_q   <= mkPend_d;
         err_q      <= err_d;
         tbtValid_q <= tbtValid_d;
         tbtI_q     <= tbtI_d;
         tbtQ_q     <= tbtQ_d;
      end
   end

   tbt_iq_accum #(.IN_W(PRODUCT_WIDTH), .ACC_W(ACC_WIDTH)) u_accI (
      .clk_i(adcClk_i), .rst_i(adcReset_i), .load_i(load), .add_i(add),
      .dump_i(dump), .sample_i(inI_i), .sum_o(sumI)
   );

   tbt_iq_accum #(.IN_W(PRODUCT_WIDTH), .ACC_W(ACC_WIDTH)) u_accQ (
      .clk_i(adcClk_i), .rst_i(adcReset_i), .load_i(load), .add_i(add),
      .dump_i(dump), .sample_i(inQ_i), .sum_o(sumQ)
   );

   assign tbtValid_o         = tbtValid_q;
   assign tbtI_o             = tbtI_q;
   assign tbtQ_o             = tbtQ_q;
   assign tbtLocked_o        = (state_q == ST_LOCKED);
   assign markerErrorCount_o = err_q;

endmodule

// File: tb/tb_tbt_iq_accumulator.sv
// Scoreboard bench for tbt_iq_accumulator: a turn-list reference model predicts
// turn sums, lock and error count; a negedge monitor compares the DUT against it.
module tb_tbt_iq_accumulator;

   localparam int SPT = 81;
   localparam int PW  = 33;
   localparam int AW  = 40;
   localparam int EW  = 16;
   localparam int ERR_MAX = (1 << EW) - 1;

   logic clk = 1'b0, rst = 1'b0, mk = 1'b0, v = 1'b0, clr = 1'b0;
   logic signed [PW-1:0] di = '0, dq = '0;
   logic                 tbtValid, tbtLocked;
   logic signed [AW-1:0] tbtI, tbtQ;
   logic [EW-1:0]        errCnt;

   tbt_iq_accumulator dut (
      .adcClk_i(clk), .adcReset_i(rst), .tbtMarker_i(mk), .inValid_i(v),
      .inI_i(di), .inQ_i(dq), .clearErrors_i(clr),
      .tbtValid_o(tbtValid), .tbtI_o(tbtI), .tbtQ_o(tbtQ),
      .tbtLocked_o(tbtLocked), .markerErrorCount_o(errCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                   cyc;
      logic signed [AW-1:0] i;
      logic signed [AW-1:0] q;
   } exp_t;

   exp_t   sb[$];
   longint turnI[$], turnQ[$];
   bit     m_lock, m_pend;
   int     m_err;
   logic signed [AW-1:0] m_i = '0, m_q = '0;
   bit     e_lock;
   int     e_err;
   logic signed [AW-1:0] e_i = '0, e_q = '0;
   int     cyc = 0, tests = 0, fails = 0;
   bit     chk = 1'b0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      e_lock <= m_lock;
      e_err  <= m_err;
      e_i    <= m_i;
      e_q    <= m_q;
   end

   task automatic check(string nm, longint got, longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         if (fails <= 30)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            tests++; fails++;
            if (fails <= 30)
               $display("FAIL tbt_missing: got no tbtValid, expected one at cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
         end
         if (tbtValid) begin
            if (sb.size() == 0) begin
               tests++; fails++;
               if (fails <= 30)
                  $display("FAIL tbt_unexpected: got tbtValid, expected none (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("tbt_cycle", cyc, e.cyc);
               check("tbt_I", tbtI, e.i);
               check("tbt_Q", tbtQ, e.q);
            end
         end
         check("locked", tbtLocked, e_lock);
         check("err_count", errCnt, e_err);
         check("hold_I", tbtI, e_i);
         check("hold_Q", tbtQ, e_q);
      end
   end

   // Reference: a turn is the list of samples since the last alignment point.
   task automatic step(bit r, bit m, bit val, longint i, longint q, bit c);
      @(posedge clk); #1;
      rst = r; mk = m; v = val; di = PW'(i); dq = PW'(q); clr = c;
      if (r) begin
         m_lock = 0; m_pend = 0; m_err = 0; m_i = '0; m_q = '0;
         turnI.delete(); turnQ.delete();
      end else begin
         bit inc = 0;
         bit p = m_pend | m;
         if (val) begin
            m_pend = 0;
            if (!m_lock) begin
               if (p) begin
                  m_lock = 1; turnI = {i}; turnQ = {q};
               end
            end else if (p && turnI.size() != 0) begin
               turnI = {i}; turnQ = {q}; inc = 1;
            end else begin
               turnI.push_back(i); turnQ.push_back(q);
            end
            if (m_lock && turnI.size() == SPT) begin
               longint si = 0, sq = 0;
               exp_t e;
               foreach (turnI[k]) si += turnI[k];
               foreach (turnQ[k]) sq += turnQ[k];
               m_i = AW'(si); m_q = AW'(sq);
               e.cyc = cyc + 1; e.i = m_i; e.q = m_q;
               sb.push_back(e);
               turnI.delete(); turnQ.delete();
            end
         end else begin
            m_pend = p;
         end
         if (inc) m_err = c ? 1 : (m_err == ERR_MAX ? ERR_MAX : m_err + 1);
         else if (c) m_err = 0;
      end
   endtask

   function automatic longint rnd33();
      logic signed [PW-1:0] r;
      r = PW'({$urandom(), $urandom()});
      return longint'(r);
   endfunction

   task automatic idle(int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
   endtask

   // n valid samples of random data with random idle gaps, no markers
   task automatic rnd_samples(int n);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         step(0, 0, 1, rnd33(), rnd33(), 0);
      end
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk = 1'b1;
      step(1, 0, 0, 0, 0, 0);
      idle(3);

      // constant turn with marker on first sample
      step(0, 1, 1, 1000, -1000, 0);
      for (int k = 1; k < SPT; k++) step(0, 0, 1, 1000, -1000, 0);
      idle(2);

      // full-scale extremes, flywheel turn
      for (int k = 0; k < SPT; k++) step(0, 0, 1, -(longint'(1) << 32), (longint'(1) << 32) - 1, 0);
      idle(2);

      // misaligned marker at cnt=40
      rnd_samples(40);
      step(0, 1, 1, rnd33(), rnd33(), 0);
      rnd_samples(SPT - 1);
      idle(2);

      // flywheel: three turns with no markers
      rnd_samples(3 * SPT);
      idle(2);

      // pending marker at cnt==0, then pending marker mid-turn
      step(0, 1, 0, 0, 0, 0);
      idle(3);
      rnd_samples(SPT);
      rnd_samples(10);
      step(0, 1, 0, 0, 0, 0);
      idle(3);
      rnd_samples(SPT);
      idle(2);

      // reset mid-turn, then clear+misalign in one cycle
      rnd_samples(50);
      step(1, 0, 0, 0, 0, 0);
      idle(2);
      step(0, 1, 1, rnd33(), rnd33(), 0);
      rnd_samples(5);
      step(0, 1, 1, rnd33(), rnd33(), 1);
      idle(2);

      // drive the error counter into saturation
      for (int k = 0; k < (1 << EW) + 4; k++) step(0, 1, 1, rnd33(), rnd33(), 0);
      idle(2);
      step(0, 0, 0, 0, 0, 1);
      idle(2);

      // random soak
      for (int k = 0; k < 3000; k++)
         step($urandom_range(0, 1499) == 0, $urandom_range(0, 119) == 0,
              $urandom_range(0, 9) < 8, rnd33(), rnd33(), $urandom_range(0, 199) == 0);
      idle(4);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
